// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_pkg
// Brief  : Shared constants and helpers for the arbitrating multiplexer.
//          Provides the clog2 constant function and the arbitration mode
//          encodings (MODE_RR = round-robin, MODE_FIXED = ch0 highest).
// Rev    : 1.0  initial release
// ============================================================================
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceiling log2, minimum result 1 so a 2-channel index is still one bit wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : N_CH-way arbiter, round-robin or fixed priority.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-channel request
//   mode       : MODE_RR / MODE_FIXED
//   advance    : a grant issued this cycle is actually taken
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted channel
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            mode,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_idx;
  logic            w_any;

  // Scan from the lowest-priority candidate to the highest so the last hit
  // wins. In round-robin mode candidates are ptr, ptr+1, ... modulo N_CH.
  always_comb begin
    int              v_c;
    logic [CH_W-1:0] v_sel;
    w_idx = '0;
    w_any = |req;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mode == MODE_RR) begin
        v_c = int'(r_ptr) + i;
        if (v_c >= N_CH) v_c = v_c - N_CH;
      end else begin
        v_c = i;
      end
      v_sel = CH_W'(v_c);
      if (req[v_sel]) w_idx = v_sel;
    end
  end

  assign grant     = w_any ? (N_CH'(1) << w_idx) : '0;
  assign grant_idx = w_idx;

  // Pointer moves just past the winner, only on a taken round-robin grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && w_any && (mode == MODE_RR)) begin
      if (w_idx == CH_W'(N_CH - 1)) r_ptr <= '0;
      else                          r_ptr <= w_idx + CH_W'(1);
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module : rr_arb_mux
// Brief  : N_CH-channel, W-bit arbitrating multiplexer with valid/ready on
//          each input and a single registered output stage.
//   clk, rst   : clock, synchronous active-high reset
//   prio_mode  : 0 = round-robin, 1 = fixed priority (ch0 highest)
//   in_valid   : per-channel valid
//   in_data    : channel k at [k*W +: W]
//   in_ready   : one-hot or zero, channel accepted this cycle
//   out_valid  : output register holds data
//   out_data   : registered data
//   out_ch     : channel that supplied out_data
//   out_ready  : consumer accepts out_data
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int CH_W = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prio_mode,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [CH_W-1:0] r_out_ch;

  logic            w_load_en;
  logic            w_advance;
  logic [N_CH-1:0] w_grant;
  logic [CH_W-1:0] w_idx;

  // The register can take a new word when empty or when its word leaves now.
  assign w_load_en = !r_out_valid || out_ready;
  // Reset suppresses any handshake so producers never see a lost accept.
  assign w_advance = w_load_en && !rst;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .mode      (prio_mode),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  assign in_ready = w_advance ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_load_en) begin
      // With no request the word (if any) drains and the register empties.
      r_out_valid <= |in_valid;
      if (|in_valid) begin
        r_out_data <= in_data[int'(w_idx)*W +: W];
        r_out_ch   <= w_idx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule : rr_arb_mux
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arb_mux
// Brief  : Directed self-checking bench for rr_arb_mux (N_CH=4, W=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_rr_arb_mux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic              prio_mode;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [1:0]        out_ch;
  logic              out_ready;

  int vec;
  int errs;

  rr_arb_mux #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prio_mode (prio_mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check the whole output register in one go.
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  initial begin
    vec       = 0;
    errs      = 0;
    rst       = 1'b1;
    prio_mode = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    cyc();
    cyc();
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);

    // Release: first grant is ch0.
    rst = 1'b0;
    #1;
    chk("first.in_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("first", 1'b1, 8'h10, 2'd0);

    // Round-robin under full load: 1,2,3,0 one word per cycle.
    for (int k = 1; k <= 4; k++) begin
      chk("rr.in_ready", 32'(in_ready), 32'(1 << (k % 4)));
      cyc();
      chk_out("rr", 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    end
    // ptr is now 1.

    // Fixed priority with ch1 and ch3 requesting: ch1 every cycle.
    prio_mode = 1'b1;
    in_valid  = 4'b1010;
    #1;
    chk("fix.in_ready", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("fix1a", 1'b1, 8'h11, 2'd1);
    cyc();
    chk_out("fix1b", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b1000;
    #1;
    chk("fix3.in_ready", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("fix3", 1'b1, 8'h13, 2'd3);

    // Back to round-robin; ptr kept its value (1) so ch1 wins.
    prio_mode = 1'b0;
    in_valid  = 4'b1111;
    cyc();
    chk_out("bp.load", 1'b1, 8'h11, 2'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'h0);
      cyc();
      chk_out("bp.hold", 1'b1, 8'h11, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.resume.in_ready", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("bp.resume", 1'b1, 8'h12, 2'd2);
    // ptr is now 3.

    // Wrap-around with sparse requests: ch0, then ch3, then ch0.
    in_valid = 4'b0001;
    #1;
    chk("wrap0.in_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("wrap0", 1'b1, 8'h10, 2'd0);
    in_valid = 4'b1001;
    cyc();
    chk_out("wrap3", 1'b1, 8'h13, 2'd3);
    cyc();
    chk_out("wrap0b", 1'b1, 8'h10, 2'd0);
    // ptr is now 1.

    // Idle: register drains.
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("idle.valid", 32'(out_valid), 32'h0);

    // Reset while stalled with a word pending.
    in_valid = 4'b1111;
    cyc();
    chk_out("mid.load", 1'b1, 8'h11, 2'd1);
    out_ready = 1'b0;
    cyc();
    chk_out("mid.hold", 1'b1, 8'h11, 2'd1);
    rst = 1'b1;
    #1;
    chk("mid.rst.in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid.restart.in_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("mid.restart", 1'b1, 8'h10, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule : tb_rr_arb_mux
`default_nettype wire
